// File: rtl/div_share_arbiter.sv
// div_share_arbiter
// Round-robin arbiter and sequencer that shares one restoring divider
// (8-bit dividend, 9-bit divisor) among N_REQ requesters. One request is served
// at a time. Divide-by-zero is answered locally. A divider that never finishes
// is cut off after DIV_TIMEOUT cycles.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot, IDLE only)
//   req_dividend           8 bits per requester, requester i at [8i+7:8i]
//   req_divisor            9 bits per requester, requester i at [9i+8:9i]
//   div_start              one-cycle start pulse to the shared divider
//   div_dividend/divisor   latched operands, stable until the response
//   div_done               divider completion strobe, with quotient/remainder
//   rsp_valid              one-cycle response pulse
//   rsp_id/quotient/remainder/err   registered response fields
//   busy                   high whenever the sequencer is not idle
module div_share_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned DIV_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_dividend,
  input  logic [9*N_REQ-1:0] req_divisor,
  output logic [N_REQ-1:0]   req_ready,
  output logic               div_start,
  output logic [7:0]         div_dividend,
  output logic [8:0]         div_divisor,
  input  logic               div_done,
  input  logic [7:0]         div_quotient,
  input  logic [8:0]         div_remainder,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_quotient,
  output logic [8:0]         rsp_remainder,
  output logic               rsp_err,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [ID_W-1:0] last_grant_q;
  logic [7:0]      dividend_q;
  logic [8:0]      divisor_q;
  logic [CntW-1:0] cnt_q;
  logic            div_start_q;
  logic            rsp_valid_q;
  logic            busy_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [7:0]      rsp_quot_q;
  logic [8:0]      rsp_rem_q;
  logic            rsp_err_q;

  // Unpack the flat operand buses.
  logic [7:0] dvd_arr [N_REQ];
  logic [8:0] dvs_arr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = req_dividend[8*g +: 8];
    assign dvs_arr[g] = req_divisor[9*g +: 9];
  end

  // Round-robin search starting just after the last grant, wrapping around.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic [7:0]      grant_dividend;
  logic [8:0]      grant_divisor;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_dividend = dvd_arr[grant_idx];
    grant_divisor  = dvs_arr[grant_idx];
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !reset && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(N_REQ - 1);
      dividend_q   <= '0;
      divisor_q    <= '0;
      cnt_q        <= '0;
      div_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_id_q     <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            last_grant_q <= grant_idx;
            rsp_id_q     <= grant_idx;
            dividend_q   <= grant_dividend;
            divisor_q    <= grant_divisor;
            busy_q       <= 1'b1;
            if (grant_divisor == '0) begin
              // Answered locally; the divider is never started.
              rsp_quot_q  <= 8'hFF;
              rsp_rem_q   <= {1'b0, grant_dividend};
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              div_start_q <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (div_done) begin
            rsp_quot_q  <= div_quotient;
            rsp_rem_q   <= div_remainder;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_q == CntW'(DIV_TIMEOUT - 1)) begin
            // Last waiting cycle elapsed: response lands DIV_TIMEOUT+1 after start.
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // rsp_id_q is also updated at accept, before RESP; expose it only through
  // the held response copy so it changes only on entry to RESP.
  logic [ID_W-1:0] rsp_id_hold_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id_hold_q <= '0;
    end else if (rsp_valid_q == 1'b0 && state_q != StResp &&
                 ((state_q == StIdle && grant_found && grant_divisor == '0) ||
                  (state_q == StWait && (div_done || cnt_q == CntW'(DIV_TIMEOUT - 1))))) begin
      rsp_id_hold_q <= (state_q == StIdle) ? grant_idx : rsp_id_q;
    end
  end

  assign div_start     = div_start_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_hold_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: directed scenarios followed by
// randomized traffic, checked against a request-level reference model.
module tb_div_share_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_dividend;
  logic [9*N-1:0] req_divisor;
  logic [N-1:0]   req_ready;
  logic           div_start;
  logic [7:0]     div_dividend;
  logic [8:0]     div_divisor;
  logic           div_done;
  logic [7:0]     div_quotient;
  logic [8:0]     div_remainder;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_quotient;
  logic [8:0]     rsp_remainder;
  logic           rsp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int lat_cfg = 9;          // divider latency; 0 means it never finishes
  int cyc = 0;
  int inject_cycle = -1;    // cycle in which a stray div_done is forced
  logic [7:0] op_a [N];
  logic [8:0] op_b [N];
  logic [N-1:0] vmask;
  int lg = N - 1;           // model of the last granted requester

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_share_arbiter #(.N_REQ(N), .ID_W(2), .DIV_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_ready(req_ready), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural divider: done lat_cfg cycles after the start pulse.
  initial begin : div_model
    int remaining;
    bit pending;
    logic [7:0] ca;
    logic [8:0] cb;
    pending = 0; remaining = 0; ca = '0; cb = '0;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (reset) begin
        pending = 0;
      end else begin
        if (cyc == inject_cycle) begin
          div_done = 1'b1; div_quotient = 8'h5A; div_remainder = 9'h1A5;
        end
        if (pending) begin
          remaining--;
          if (remaining == 0) begin
            div_done      = 1'b1;
            div_quotient  = (cb == 0) ? 8'h00 : 8'(ca / cb);
            div_remainder = (cb == 0) ? 9'h000 : 9'(ca % cb);
            pending       = 0;
          end
        end
        if (div_start && lat_cfg > 0) begin
          pending = 1; remaining = lat_cfg; ca = div_dividend; cb = div_divisor;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive();
    req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      req_dividend[8*i +: 8] = op_a[i];
      req_divisor[9*i +: 9]  = op_b[i];
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_start"}, div_start, 0);
    chk({tag, "_dvd"}, div_dividend, 0);
    chk({tag, "_dvs"}, div_divisor, 0);
    chk({tag, "_rvalid"}, rsp_valid, 0);
    chk({tag, "_rid"}, rsp_id, 0);
    chk({tag, "_rq"}, rsp_quotient, 0);
    chk({tag, "_rr"}, rsp_remainder, 0);
    chk({tag, "_rerr"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; #1;
    check_all_zero(tag);
    step();
    reset = 1'b0; lg = N - 1; #1;
  endtask

  // One complete transaction for requester exp_id, from grant to idle.
  task automatic txn(input int exp_id, input int lat, input bit hold);
    logic [7:0] a;
    logic [8:0] b;
    int n;
    bit hold_ok;
    lat_cfg = lat;
    #1;
    chk("grant", req_ready, 32'(1) << exp_id);
    a = op_a[exp_id]; b = op_b[exp_id]; lg = exp_id;
    step();
    if (hold) begin
      op_a[exp_id] = 8'($urandom);
      op_b[exp_id] = 9'($urandom_range(1, 511));
    end else begin
      vmask[exp_id] = 1'b0;
    end
    drive(); #1;
    chk("ready_low", req_ready, 0);
    chk("busy_high", busy, 1);
    if (b == 0) begin
      chk("dz_valid", rsp_valid, 1);
      chk("dz_start", div_start, 0);
      chk("dz_id", rsp_id, exp_id);
      chk("dz_q", rsp_quotient, 8'hFF);
      chk("dz_r", rsp_remainder, {1'b0, a});
      chk("dz_err", rsp_err, 1);
    end else begin
      chk("start", div_start, 1);
      chk("start_dvd", div_dividend, a);
      chk("start_dvs", div_divisor, b);
      n = -1; hold_ok = 1;
      for (int c = 1; c <= 40 && n < 0; c++) begin
        step();
        if (!hold) begin
          op_a[exp_id] = 8'($urandom);  // requester changes its bus while waiting
          drive();
        end
        #1;
        if (div_start || div_dividend !== a || div_divisor !== b) hold_ok = 0;
        if (rsp_valid) n = c;
      end
      chk("op_hold", hold_ok, 1);
      chk("latency", n, (lat > 0) ? lat + 1 : TMO + 1);
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_q", rsp_quotient, (lat > 0) ? 32'(a / b) : 0);
      chk("rsp_r", rsp_remainder, (lat > 0) ? 32'(a % b) : 0);
      chk("rsp_err", rsp_err, (lat > 0) ? 0 : 1);
    end
    step(); #1;
    chk("rsp_pulse", rsp_valid, 0);
    chk("idle", busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bad;
    int id;
    int lat;
    reset = 1'b1;
    vmask = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = 9'd1; end
    drive();
    repeat (2) step();
    #1;
    check_all_zero("rst");
    vmask = 4'hF; drive(); #1;
    chk("rst_ready_gated", req_ready, 0);
    vmask = '0; drive();
    step();
    reset = 1'b0; #1;
    check_all_zero("post_rst");

    // Single request: requester 2, 200/7.
    op_a[2] = 8'd200; op_b[2] = 9'd7; vmask = 4'b0100; drive();
    txn(2, 9, 0);
    chk("single_q_const", 200 / 7, 28);

    // Round robin with every requester holding valid.
    do_reset("rr_rst");
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'($urandom); op_b[i] = 9'($urandom_range(1, 511));
    end
    vmask = 4'hF; drive();
    for (int g = 0; g < 5; g++) txn(g % N, $urandom_range(1, 15), 1);
    vmask = '0; drive();

    // Divide-by-zero.
    op_a[1] = 8'd55; op_b[1] = 9'd0; vmask = 4'b0010; drive();
    txn(1, 9, 0);

    // Timeout, then a late done that must be ignored.
    op_a[3] = 8'($urandom); op_b[3] = 9'($urandom_range(1, 511)); vmask = 4'b1000; drive();
    txn(3, 0, 0);
    inject_cycle = cyc + 1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      if (rsp_valid || busy) bad++;
    end
    chk("late_done_ignored", bad, 0);

    // Reset three cycles after div_start.
    op_a[3] = 8'($urandom); op_b[3] = 9'($urandom_range(1, 511)); vmask = 4'b1000; drive();
    lat_cfg = 9; #1;
    chk("mw_grant", req_ready, 4'b1000);
    step();
    for (int i = 0; i < 3; i++) begin
      op_a[i] = 8'($urandom); op_b[i] = 9'($urandom_range(1, 511));
    end
    vmask = 4'hF; drive(); #1;
    chk("mw_start", div_start, 1);
    repeat (3) step();
    do_reset("mw_rst");
    chk("mw_no_rsp", rsp_valid, 0);
    chk("mw_first_grant", req_ready, 4'b0001);
    txn(0, 9, 0);

    // Randomized traffic.
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!vmask[i] && $urandom_range(0, 1) == 1) begin
          vmask[i] = 1'b1;
          op_a[i] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) op_b[i] = 9'd0;
          else op_b[i] = 9'($urandom_range(1, 511));
        end
      end
      if (vmask == '0) begin
        vmask[0] = 1'b1; op_a[0] = 8'($urandom); op_b[0] = 9'($urandom_range(1, 511));
      end
      drive();
      id = rr_pick(vmask, lg);
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      txn(id, lat, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Round-robin arbiter and sequencer that shares one 8-bit-dividend / 9-bit-divisor restoring divider among `N_REQ` requesters. It accepts one request at a time, issues it to the divider with a start pulse, waits for completion (with timeout), and returns the result tagged with the requester ID. Divide-by-zero is resolved locally without occupying the divider. The block sits between the requesting datapath units and the single shared divider instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester ID width, equal to clog2(`N_REQ`).
- `DIV_TIMEOUT`, 16: maximum cycles to wait for `div_done` after `div_start`. Must be ≥ divider latency + 1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_dividend`  in  8*`N_REQ`  requester i occupies bits [8i+7:8i].
- `req_divisor`  in  9*`N_REQ`  requester i occupies bits [9i+8:9i].
- `req_ready`  out  `N_REQ`  one-hot accept; transfer when `req_valid[i]` & `req_ready[i]`.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_dividend`  out  8  operand, held stable from `div_start` until the response.
- `div_divisor`  out  9  operand, held stable from `div_start` until the response.
- `div_done`  in  1  divider completion strobe.
- `div_quotient`  in  8  divider result, valid with `div_done`.
- `div_remainder`  in  9  divider result, valid with `div_done`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  `ID_W`  index of the served requester.
- `rsp_quotient`  out  8  result quotient.
- `rsp_remainder`  out  9  result remainder.
- `rsp_err`  out  1  1 = divide-by-zero or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready` is combinational: one-hot on the first asserted `req_valid`, searching from `last_grant+1` upward with wrap-around. If no `req_valid` is asserted, `req_ready` is all zero. On transfer:
  - latch the operands and ID;
  - set `last_grant` to the granted index;
  - if the divisor is 0, go to RESP; otherwise go to ISSUE.
- **ISSUE:** assert `div_start` for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT:**
  - On `div_done`: capture the quotient and remainder, clear the error, go to RESP.
  - When the counter reaches `DIV_TIMEOUT` without `div_done`: quotient 0, remainder 0, error set, go to RESP.
- **RESP:** `rsp_valid` = 1 for one cycle with the registered fields, then go to IDLE.
- **Divide-by-zero:** quotient 8'hFF, remainder = zero-extended dividend, error set.
- `div_done` outside WAIT, including a late done after a timeout, is ignored.
- `req_ready` is 0 in every state except IDLE, so requesters hold their `req_valid`. No request is dropped or accepted twice.
- **Fairness:** a requester that holds `req_valid` is granted within `N_REQ` grants.

## Timing
- Reset values:
  - `req_ready`, `div_start`, `rsp_valid`, `rsp_err`, `busy`: 0.
  - All data outputs: 0.
  - `rsp_id`: 0.
  - State: IDLE.
  - `last_grant`: `N_REQ`-1, so requester 0 has first priority.
- **Reset mid-operation:** everything returns to the reset values immediately. An in-flight result is discarded and no `rsp_valid` is produced for it.
- **Normal latency:** accept at edge T, `div_start` high in cycle T+1. If `div_done` arrives L cycles after `div_start`, `rsp_valid` is high the cycle after `div_done`. The next accept is possible in the cycle after `rsp_valid`.
- **Divide-by-zero:** accept at T, `rsp_valid` in cycle T+1, `div_start` never asserted.
- **Timeout:** `rsp_valid` rises `DIV_TIMEOUT`+1 cycles after `div_start`.
- Response fields change only when entering RESP and hold until the next RESP.

## Test plan
- **Single request:** reset, then requester 2 sends 200/7.
  - Required: `req_ready`=4'b0100 for one cycle, one `div_start` pulse with operands 200/7.
  - With a divider model of latency 9: `rsp_valid` once with id 2, quotient 28, remainder 4, err 0.
- **Round robin:** all 4 requesters hold `req_valid` continuously.
  - Required: grant order 0,1,2,3,0, each followed by its response before the next grant.
- **Divide-by-zero:** requester 1 sends 55/0.
  - Required: `rsp_valid` in the cycle after the accept with quotient FF, remainder 55, err 1, and no `div_start`.
- **Timeout:** the divider model never raises `div_done`.
  - Required: `rsp_valid` 17 cycles after `div_start` with quotient 0, remainder 0, err 1.
  - A `div_done` injected 2 cycles later produces no response.
- **Reset mid-WAIT:** assert `reset` 3 cycles after `div_start`.
  - Required: all outputs 0 at once, no response, and requester 0 is granted first after reset.
- **Operand hold:** change `req_dividend` of the granted requester during WAIT.
  - Required: `div_dividend` is unchanged and the result matches the latched operands.
